// File: rtl/gate_bist_checker.sv
// Exhaustive two-input gate BIST checker.
// Steps {a,b} through 00,01,10,11, holds each vector for SETTLE cycles,
// then compares y against the expected truth table for one cycle.
// Reports a per-vector fail map, a mismatch count and an overall pass flag.
// SETTLE must lie in 1..15 so that it fits the 4-bit wait counter.
module gate_bist_checker #(
  parameter logic [3:0]  EXP_TT = 4'b1000,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       pass_out,
  output logic [2:0] err_cnt_out,
  output logic [3:0] fail_vec_out
);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_t;

  state_t     state_q;
  logic [1:0] idx_q;
  logic [3:0] wait_q;

  logic       mismatch;
  logic [2:0] err_nxt;
  logic [1:0] idx_nxt;

  // Compare result and the count it would produce; only acted on in StSample.
  always_comb begin
    mismatch = (y_in != EXP_TT[idx_q]);
    err_nxt  = err_cnt_out + {2'b00, mismatch};
    idx_nxt  = idx_q + 2'd1;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      idx_q        <= 2'd0;
      wait_q       <= 4'd0;
      a_out        <= 1'b0;
      b_out        <= 1'b0;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
      pass_out     <= 1'b0;
      err_cnt_out  <= 3'd0;
      fail_vec_out <= 4'd0;
    end else begin
      done_out <= 1'b0;
      unique case (state_q)
        StIdle: begin
          a_out    <= 1'b0;
          b_out    <= 1'b0;
          busy_out <= 1'b0;
          if (start_in) begin
            state_q      <= StDrive;
            idx_q        <= 2'd0;
            wait_q       <= 4'd0;
            err_cnt_out  <= 3'd0;
            fail_vec_out <= 4'd0;
            pass_out     <= 1'b0;
            busy_out     <= 1'b1;
          end
        end
        StDrive: begin
          if (wait_q == 4'(SETTLE - 1)) begin
            state_q <= StSample;
            wait_q  <= 4'd0;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        StSample: begin
          if (mismatch) begin
            fail_vec_out[idx_q] <= 1'b1;
            err_cnt_out         <= err_nxt;
          end
          if (idx_q == 2'd3) begin
            state_q  <= StDone;
            a_out    <= 1'b0;
            b_out    <= 1'b0;
            busy_out <= 1'b0;
            done_out <= 1'b1;
            // err_nxt already folds in this final compare.
            pass_out <= (err_nxt == 3'd0);
          end else begin
            state_q <= StDrive;
            idx_q   <= idx_nxt;
            wait_q  <= 4'd0;
            a_out   <= idx_nxt[1];
            b_out   <= idx_nxt[0];
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Self-checking bench for gate_bist_checker (EXP_TT = AND, SETTLE = 2).
// A behavioural gate model drives y from a/b; expected run results are
// queued when a run is started and compared when done pulses.
module tb_gate_bist_checker;

  logic       clk;
  logic       rst;
  logic       start;
  logic       y;
  logic       a, b, busy, done, pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_vec;

  int  mode;
  bit  junk;
  int  n_tests;
  int  n_fail;

  typedef struct {
    int         mode;      // 0 AND, 1 stuck0, 2 stuck1, 3 OR, 4 XOR, 5 NAND
    bit         junk;      // corrupt y outside the sample cycle
    bit         exp_pass;
    logic [2:0] exp_err;
    logic [3:0] exp_fv;
  } vec_t;

  vec_t vecs[7];
  vec_t sb_q[$];
  vec_t v_and;

  gate_bist_checker #(
    .EXP_TT(4'b1000),
    .SETTLE(2)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .start_in    (start),
    .y_in        (y),
    .a_out       (a),
    .b_out       (b),
    .busy_out    (busy),
    .done_out    (done),
    .pass_out    (pass),
    .err_cnt_out (err_cnt),
    .fail_vec_out(fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic gate(input int m, input logic ai, input logic bi);
    case (m)
      0:       return ai & bi;
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ai | bi;
      4:       return ai ^ bi;
      default: return ~(ai & bi);
    endcase
  endfunction

  assign y = gate(mode, a, b) ^ junk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Queue expectation, present start before an edge; returns just after the accepting edge.
  task automatic begin_run(input vec_t v);
    sb_q.push_back(v);
    @(negedge clk);
    mode  = v.mode;
    start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Walks edges 0..11 after the accepting edge, then checks the done cycle.
  task automatic run_body(input bit hold, input bit glitch, input vec_t v);
    vec_t       e_v;
    logic [1:0] idx;
    for (int e = 0; e < 12; e++) begin
      idx  = 2'(e / 3);
      junk = v.junk && ((e % 3) != 2);
      chk("a_seq", {31'd0, a}, {31'd0, idx[1]});
      chk("b_seq", {31'd0, b}, {31'd0, idx[0]});
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("done_early", {31'd0, done}, 32'd0);
      @(negedge clk);
      if (!hold) start = glitch && (e == 3 || e == 7);
      @(posedge clk);
      #1;
    end
    junk = 1'b0;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    if (sb_q.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e_v = sb_q.pop_front();
      chk("pass", {31'd0, pass}, {31'd0, e_v.exp_pass});
      chk("err_cnt", {29'd0, err_cnt}, {29'd0, e_v.exp_err});
      chk("fail_vec", {28'd0, fail_vec}, {28'd0, e_v.exp_fv});
    end
  endtask

  // One cycle after done: back in idle, results held.
  task automatic post_idle(input vec_t v);
    @(posedge clk);
    #1;
    chk("done_clear", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("pass_hold", {31'd0, pass}, {31'd0, v.exp_pass});
    chk("err_hold", {29'd0, err_cnt}, {29'd0, v.exp_err});
    chk("fv_hold", {28'd0, fail_vec}, {28'd0, v.exp_fv});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    mode    = 0;
    junk    = 1'b0;

    // Expected results derived by hand against EXP_TT = 1000 (AND).
    vecs[0] = '{0, 1'b0, 1'b1, 3'd0, 4'b0000};  // AND, correct
    vecs[1] = '{1, 1'b0, 1'b0, 3'd1, 4'b1000};  // stuck at 0
    vecs[2] = '{2, 1'b0, 1'b0, 3'd3, 4'b0111};  // stuck at 1
    vecs[3] = '{3, 1'b0, 1'b0, 3'd2, 4'b0110};  // OR
    vecs[4] = '{4, 1'b0, 1'b0, 3'd3, 4'b1110};  // XOR
    vecs[5] = '{5, 1'b0, 1'b0, 3'd4, 4'b1111};  // NAND: count reaches 4
    vecs[6] = '{0, 1'b1, 1'b1, 3'd0, 4'b0000};  // AND with noise outside sample
    v_and   = vecs[0];

    #12;
    chk("rst_a", {31'd0, a}, 32'd0);
    chk("rst_b", {31'd0, b}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_err", {29'd0, err_cnt}, 32'd0);
    chk("rst_fv", {28'd0, fail_vec}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven runs.
    for (int i = 0; i < 7; i++) begin
      begin_run(vecs[i]);
      run_body(1'b0, 1'b0, vecs[i]);
      post_idle(vecs[i]);
    end

    // Start pulses during a run are ignored.
    begin_run(v_and);
    run_body(1'b0, 1'b1, v_and);
    post_idle(v_and);

    // Start held high: back-to-back runs with done/idle gap.
    begin_run(v_and);
    run_body(1'b1, 1'b0, v_and);
    @(posedge clk);
    #1;
    chk("hold_gap_busy", {31'd0, busy}, 32'd0);
    chk("hold_gap_done", {31'd0, done}, 32'd0);
    chk("hold_gap_pass", {31'd0, pass}, 32'd1);
    sb_q.push_back(v_and);
    @(posedge clk);
    #1;
    run_body(1'b1, 1'b0, v_and);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_end_done", {31'd0, done}, 32'd0);
    chk("hold_end_busy", {31'd0, busy}, 32'd0);

    // Mid-run asynchronous reset with accumulated errors and nonzero stimulus.
    @(negedge clk);
    mode  = 2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("pre_rst_err", {29'd0, err_cnt}, 32'd1);
    chk("pre_rst_b", {31'd0, b}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_a", {31'd0, a}, 32'd0);
    chk("arst_b", {31'd0, b}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_pass", {31'd0, pass}, 32'd0);
    chk("arst_err", {29'd0, err_cnt}, 32'd0);
    chk("arst_fv", {28'd0, fail_vec}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("arst_no_done", {31'd0, done}, 32'd0);
      chk("arst_no_busy", {31'd0, busy}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    begin_run(v_and);
    run_body(1'b0, 1'b0, v_and);
    post_idle(v_and);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
